// File: rtl/apb4_master_mux_if.sv
// Bundle of request/response and APB4 bus signals between a requester, the
// multi-slave APB4 master and its slaves.
interface apb4_master_mux_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 4
);
    logic                             req_valid;
    logic                             req_ready;
    logic                             req_write;
    logic [ADDR_WIDTH-1:0]            req_addr;
    logic [DATA_WIDTH-1:0]            req_wdata;
    logic [DATA_WIDTH/8-1:0]          req_strb;
    logic [2:0]                       req_prot;
    logic                             rsp_valid;
    logic [DATA_WIDTH-1:0]            rsp_rdata;
    logic                             rsp_err;
    logic                             rsp_timeout;
    logic [ADDR_WIDTH-1:0]            Paddr;
    logic [DATA_WIDTH-1:0]            Pwdata;
    logic                             Pwrite;
    logic [DATA_WIDTH/8-1:0]          Pstrb;
    logic [2:0]                       Pprot;
    logic [NUM_SLAVES-1:0]            Psel;
    logic                             Penable;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] Prdata_in;
    logic [NUM_SLAVES-1:0]            Pready;
    logic [NUM_SLAVES-1:0]            Pslverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
        input  Prdata_in, Pready, Pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output Paddr, Pwdata, Pwrite, Pstrb, Pprot, Psel, Penable
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
        output Prdata_in, Pready, Pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  Paddr, Pwdata, Pwrite, Pstrb, Pprot, Psel, Penable
    );
endinterface

// File: rtl/apb4_master_mux.sv
// APB4 master fanning out to NUM_SLAVES slaves: valid/ready requests, one-hot
// address decode, PREADY timeout, decode error and a registered response pulse.
module apb4_master_mux #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_SLAVES   = 4,
    parameter int SLV_ADDR_LSB = 28,
    parameter int TIMEOUT      = 16
) (
    input logic               Pclk,
    input logic               Preset,
    apb4_master_mux_if.master bus
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int SEL_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_DECERR = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  dec_pend_q, dec_pend_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  pwrite_q, pwrite_d;
    logic [STRB_W-1:0]     pstrb_q, pstrb_d;
    logic [2:0]            pprot_q, pprot_d;
    logic [NUM_SLAVES-1:0] psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  rsp_timeout_q, rsp_timeout_d;

    logic [SEL_W-1:0]      req_idx;
    logic                  dec_ok;
    logic [NUM_SLAVES-1:0] psel_dec;
    logic                  pready_sel;
    logic                  pslverr_sel;
    logic [DATA_WIDTH-1:0] prdata_sel;
    logic                  timeout_hit;
    logic                  req_ready;
    logic                  accept;

    assign req_idx = bus.req_addr[SLV_ADDR_LSB +: SEL_W];
    assign dec_ok  = int'(req_idx) < NUM_SLAVES;

    // Psel is one-hot while a transfer is live, so it doubles as the response mux select.
    always_comb begin
        psel_dec   = '0;
        prdata_sel = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            psel_dec[k] = (int'(req_idx) == k);
            if (psel_q[k]) begin
                prdata_sel = prdata_sel | bus.Prdata_in[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign pready_sel  = |(bus.Pready & psel_q);
    assign pslverr_sel = |(bus.Pslverr & psel_q);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST)) && !pready_sel;
    assign req_ready   = (state_q == ST_IDLE) || ((state_q == ST_ACCESS) && pready_sel);
    assign accept      = bus.req_valid && req_ready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        dec_pend_d    = 1'b0;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pwrite_d      = pwrite_q;
        pstrb_d       = pstrb_q;
        pprot_d       = pprot_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = '0;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;

        case (state_q)
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ST_ACCESS: begin
                if (pready_sel) begin
                    state_d     = ST_IDLE;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = pslverr_sel;
                    rsp_rdata_d = (!pwrite_q && !pslverr_sel) ? prdata_sel : '0;
                end else if (timeout_hit) begin
                    state_d       = ST_IDLE;
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DECERR: begin
                state_d = ST_IDLE;
                if (dec_pend_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
            end
            default: ;
        endcase

        // A decode error accepted on a completing cycle defers its pulse one cycle
        // so it does not collide with the completion response.
        if (accept) begin
            cnt_d = '0;
            if (dec_ok) begin
                state_d   = ST_SETUP;
                paddr_d   = bus.req_addr;
                pwdata_d  = bus.req_wdata;
                pwrite_d  = bus.req_write;
                pstrb_d   = bus.req_write ? bus.req_strb : '0;
                pprot_d   = bus.req_prot;
                psel_d    = psel_dec;
                penable_d = 1'b0;
            end else begin
                state_d   = ST_DECERR;
                psel_d    = '0;
                penable_d = 1'b0;
                if (state_q == ST_IDLE) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    dec_pend_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Pclk) begin
        if (Preset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            dec_pend_q    <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pwrite_q      <= 1'b0;
            pstrb_q       <= '0;
            pprot_q       <= '0;
            psel_q        <= '0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dec_pend_q    <= dec_pend_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pwrite_q      <= pwrite_d;
            pstrb_q       <= pstrb_d;
            pprot_q       <= pprot_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus.req_ready   = req_ready;
    assign bus.Paddr       = paddr_q;
    assign bus.Pwdata      = pwdata_q;
    assign bus.Pwrite      = pwrite_q;
    assign bus.Pstrb       = pstrb_q;
    assign bus.Pprot       = pprot_q;
    assign bus.Psel        = psel_q;
    assign bus.Penable     = penable_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;
endmodule
